// File: rtl/image_loader_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_loader_param_pkg
// Description : Shared FSM state encoding, pixel-format codes and SD block size
// Revision    : 1.0 - initial release
// ============================================================================
package image_loader_param_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FMT_RGB888 = 3;
    localparam int FMT_RGB565 = 2;
    localparam int BLK_BYTES  = 512;

endpackage
`default_nettype wire

// File: rtl/image_loader_param_fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : image_loader_param_fb_ram
// Description : Simple dual-port frame buffer, one write port and one
//               registered read port (read-before-write on collision)
// Revision    : 1.0 - initial release
// ============================================================================
module image_loader_param_fb_ram #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/image_loader_param.sv
`default_nettype none
// ============================================================================
// Module      : image_loader_param
// Description : Streams one stored image from SD blocks into a frame buffer,
//               reducing each pixel to CBITS per colour channel
// Revision    : 1.0 - initial release
// ============================================================================
module image_loader_param
    import image_loader_param_pkg::*;
#(
    parameter int          IMG_W      = 320,
    parameter int          IMG_H      = 240,
    parameter int          IN_BPP     = 3,
    parameter int          CBITS      = 4,
    parameter int          NUM_IMG    = 4,
    parameter logic [31:0] BASE_BLK   = 32'h0,
    parameter logic [31:0] IMG_STRIDE = 32'h00010000,
    parameter int          TMO        = 65535,
    localparam int         NPIX       = IMG_W * IMG_H,
    localparam int         AW         = $clog2(NPIX),
    localparam int         SW         = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         sd_data_in,
    input  logic               sd_data_valid,
    input  logic               sd_ready,
    output logic [31:0]        sd_block_addr,
    output logic               sd_read_block,
    input  logic [SW-1:0]      image_select,
    input  logic               load_start,
    output logic               busy,
    output logic               done,
    output logic               error,
    input  logic [AW-1:0]      addrb,
    output logic [3*CBITS-1:0] dataOut
);

    localparam int              c_TW       = $clog2(TMO + 1);
    localparam logic [AW:0]     c_NPIX     = (AW + 1)'(NPIX);
    localparam logic [8:0]      c_BLK_LAST = 9'(BLK_BYTES - 1);
    localparam logic [1:0]      c_PH_LAST  = 2'(IN_BPP - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TMO - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_blk_addr;
    logic [8:0]           r_byte_cnt;
    logic [1:0]           r_phase;
    logic [AW:0]          r_pix_cnt;
    logic [AW:0]          w_pix_nxt;
    logic [7:0]           r_b0;
    logic [7:0]           r_b1;
    logic [c_TW-1:0]      r_tmo_cnt;
    logic                 r_error;
    logic                 r_wr_en;
    logic [AW-1:0]        r_wr_addr;
    logic [3*CBITS-1:0]   r_wr_data;
    logic [3*CBITS-1:0]   w_pix;
    logic                 w_sel_ok;
    logic                 w_accept;
    logic                 w_byte;
    logic                 w_pix_done;
    logic                 w_pix_wr;
    logic                 w_blk_end;
    logic                 w_timeout;

    assign w_sel_ok   = 32'(image_select) < 32'(NUM_IMG);
    assign w_accept   = (r_state == IDLE) && load_start;
    assign w_byte     = (r_state == RECV) && sd_data_valid;
    assign w_pix_done = w_byte && (r_phase == c_PH_LAST);
    assign w_pix_wr   = w_pix_done && (r_pix_cnt != c_NPIX);
    assign w_pix_nxt  = r_pix_cnt + (AW + 1)'(w_pix_wr);
    assign w_blk_end  = w_byte && (r_byte_cnt == c_BLK_LAST);
    assign w_timeout  = (r_state == RECV) && !sd_data_valid && (r_tmo_cnt == c_TMO_LAST);

    // The last byte of a pixel is taken straight from the bus, earlier ones from r_b0/r_b1
    if (IN_BPP == FMT_RGB565) begin : g_rgb565
        logic [15:0] w_word;
        assign w_word = {r_b0, sd_data_in};
        assign w_pix  = {w_word[15:16-CBITS], w_word[10:11-CBITS], w_word[4:5-CBITS]};
    end else begin : g_rgb888
        assign w_pix = {r_b0[7:8-CBITS], r_b1[7:8-CBITS], sd_data_in[7:8-CBITS]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        sd_read_block = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_sel_ok) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (sd_ready) begin
                    sd_read_block = 1'b1;
                    w_state_nxt   = RECV;
                end
            end
            RECV: begin
                busy = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else if (w_blk_end) begin
                    w_state_nxt = (w_pix_nxt == c_NPIX) ? DONE : REQ;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_addr <= BASE_BLK;
            r_byte_cnt <= '0;
            r_phase    <= '0;
            r_pix_cnt  <= '0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_tmo_cnt  <= '0;
            r_error    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_pix_wr;
            if (w_pix_wr) begin
                r_wr_addr <= r_pix_cnt[AW-1:0];
                r_wr_data <= w_pix;
            end
            if (w_accept) begin
                if (w_sel_ok) begin
                    r_error    <= 1'b0;
                    r_blk_addr <= BASE_BLK + 32'(image_select) * IMG_STRIDE;
                    r_byte_cnt <= '0;
                    r_phase    <= '0;
                    r_pix_cnt  <= '0;
                end else begin
                    r_error <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            if (w_byte) begin
                r_byte_cnt <= r_byte_cnt + 9'd1;
                r_pix_cnt  <= w_pix_nxt;
                r_phase    <= w_pix_done ? 2'd0 : r_phase + 2'd1;
                if (r_phase == 2'd0) r_b0 <= sd_data_in;
                if (r_phase == 2'd1) r_b1 <= sd_data_in;
                // Advance to the next block only if another read will follow
                if (w_blk_end && (w_pix_nxt != c_NPIX)) begin
                    r_blk_addr <= r_blk_addr + 32'd1;
                end
            end
            if (r_state == RECV) begin
                r_tmo_cnt <= sd_data_valid ? '0 : r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign sd_block_addr = r_blk_addr;
    assign error         = r_error;

    image_loader_param_fb_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (3 * CBITS)
    ) u_fb_ram (
        .clk     (clk),
        .i_we    (r_wr_en),
        .i_waddr (r_wr_addr),
        .i_wdata (r_wr_data),
        .i_raddr (addrb),
        .o_rdata (dataOut)
    );

endmodule
`default_nettype wire

// File: tb/tb_image_loader_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_loader_param
// Description : Self-checking bench: RGB888 8x4 loader and RGB565 16x20 loader
//               fed from a scripted SD byte source, frame checked by readback
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_loader_param;

    localparam int TMO_C = 64;

    logic        clk           = 1'b0;
    logic        reset_n       = 1'b0;
    logic [7:0]  sd_data_in    = 8'h00;
    logic        sd_data_valid = 1'b0;
    logic        sd_ready      = 1'b1;

    logic [31:0] a_addr;
    logic        a_rd, a_busy, a_done, a_err;
    logic [1:0]  a_sel   = 2'd0;
    logic        a_ls    = 1'b0;
    logic [4:0]  a_addrb = 5'd0;
    logic [11:0] a_dout;

    logic [31:0] b_addr;
    logic        b_rd, b_busy, b_done, b_err;
    logic [2:0]  b_sel   = 3'd0;
    logic        b_ls    = 1'b0;
    logic [8:0]  b_addrb = 9'd0;
    logic [11:0] b_dout;

    int checks     = 0;
    int failures   = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    logic [31:0] a_rdq[$];
    logic [31:0] b_rdq[$];
    logic [11:0] exp_q[$];

    image_loader_param #(
        .IMG_W(8), .IMG_H(4), .IN_BPP(3), .CBITS(4), .NUM_IMG(4), .TMO(TMO_C)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sd_data_in(sd_data_in), .sd_data_valid(sd_data_valid),
        .sd_ready(sd_ready), .sd_block_addr(a_addr), .sd_read_block(a_rd),
        .image_select(a_sel), .load_start(a_ls), .busy(a_busy), .done(a_done),
        .error(a_err), .addrb(a_addrb), .dataOut(a_dout)
    );

    image_loader_param #(
        .IMG_W(16), .IMG_H(20), .IN_BPP(2), .CBITS(4), .NUM_IMG(5), .TMO(TMO_C)
    ) dut565 (
        .clk(clk), .reset_n(reset_n), .sd_data_in(sd_data_in), .sd_data_valid(sd_data_valid),
        .sd_ready(sd_ready), .sd_block_addr(b_addr), .sd_read_block(b_rd),
        .image_select(b_sel), .load_start(b_ls), .busy(b_busy), .done(b_done),
        .error(b_err), .addrb(b_addrb), .dataOut(b_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_rd) a_rdq.push_back(a_addr);
        if (b_rd) b_rdq.push_back(b_addr);
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    function automatic logic [7:0] gen_byte(input bit which, input int k, input int seed);
        if (!which) return (k < 96) ? 8'(k + seed) : 8'hC3;
        if (k == 510) return 8'hF8;
        if (k == 511) return 8'h1F;
        return (k < 640) ? 8'(k * 7 + seed) : 8'h3C;
    endfunction

    function automatic logic [11:0] exp_pix(input bit which, input int k_last, input int seed);
        logic [7:0]  b0, b1, b2;
        logic [15:0] w;
        if (!which) begin
            b0 = gen_byte(1'b0, k_last - 2, seed);
            b1 = gen_byte(1'b0, k_last - 1, seed);
            b2 = gen_byte(1'b0, k_last, seed);
            return {b0[7:4], b1[7:4], b2[7:4]};
        end
        w = {gen_byte(1'b1, k_last - 1, seed), gen_byte(1'b1, k_last, seed)};
        return {w[15:12], w[10:7], w[4:1]};
    endfunction

    task automatic pulse_load(input bit which, input int sel);
        @(negedge clk);
        if (which) begin b_sel = 3'(sel); b_ls = 1'b1; end
        else       begin a_sel = 2'(sel); a_ls = 1'b1; end
        @(negedge clk);
        a_ls = 1'b0;
        b_ls = 1'b0;
    endtask

    // stop_at aborts the stream at that byte: reset pulse or a TMO-long stall
    task automatic stream(input bit which, input int seed, input int stop_at,
                          input bit stop_is_reset, input int ls_at);
        int  nblk   = which ? 2 : 1;
        int  nbytes = which ? 640 : 96;
        int  bpp    = which ? 2 : 3;
        bit  got;
        for (int blk = 0; blk < nblk; blk++) begin
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (which ? b_rd : a_rd) begin got = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL read_request blk=%0d: sd_read_block=0, required 1 within 20 cycles", blk);
                return;
            end
            for (int i = 0; i < 512; i++) begin
                int k = blk * 512 + i;
                @(negedge clk);
                a_ls = (k == ls_at);
                if (k == stop_at) begin
                    sd_data_valid = 1'b0;
                    if (stop_is_reset) reset_n = 1'b0;
                    else repeat (TMO_C + 6) @(negedge clk);
                    return;
                end
                sd_data_valid = 1'b1;
                sd_data_in    = gen_byte(which, k, seed);
                if (k < nbytes && (k % bpp) == bpp - 1) exp_q.push_back(exp_pix(which, k, seed));
            end
            @(negedge clk);
            sd_data_valid = 1'b0;
            a_ls          = 1'b0;
        end
    endtask

    task automatic read_px(input bit which, input int p, output logic [11:0] v);
        if (which) b_addrb = 9'(p); else a_addrb = 5'(p);
        @(negedge clk);
        v = which ? b_dout : a_dout;
    endtask

    task automatic check_frame(input bit which, input string name);
        logic [11:0] e, got;
        int p;
        p = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_px(which, p, got);
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s_pixel[%0d]: dataOut=%03h required %03h", name, p, got, e);
            end
            p++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_err, a_rd} !== 4'b0000 || a_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: busy/done/err/rd=%b addr=%h required 0000 / 00000000",
                     {a_busy, a_done, a_err, a_rd}, a_addr);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({b_busy, b_done, b_err, b_rd} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release565: busy/done/err/rd=%b required 0000", {b_busy, b_done, b_err, b_rd});
        end
    endtask

    task automatic check_load_end(input string name, input int d0, input logic [31:0] exp_addr);
        logic [31:0] first;
        repeat (5) @(negedge clk);
        first = (a_rdq.size() > 0) ? a_rdq[0] : 32'hFFFF_FFFF;
        checks++;
        if (a_rdq.size() != 1 || first !== exp_addr) begin
            failures++;
            $display("FAIL %s_reads: count=%0d addr=%h required 1 / %h", name, a_rdq.size(), first, exp_addr);
        end
        checks++;
        if (a_done_cnt - d0 != 1 || a_busy !== 1'b0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: pulses=%0d busy=%b err=%b required 1/0/0", name, a_done_cnt - d0, a_busy, a_err);
        end
    endtask

    task automatic test_load_img2();
        int d0 = a_done_cnt;
        logic [11:0] v;
        a_rdq.delete(); exp_q.delete();
        pulse_load(1'b0, 2);
        stream(1'b0, 0, -1, 1'b0, -1);
        check_load_end("img2", d0, 32'h0002_0000);
        check_frame(1'b0, "img2");
        read_px(1'b0, 0, v);
        checks++;
        if (v !== 12'h000) begin failures++; $display("FAIL img2_px0: dataOut=%03h required 000", v); end
        read_px(1'b0, 31, v);
        checks++;
        if (v !== 12'h555) begin failures++; $display("FAIL img2_px31: dataOut=%03h required 555", v); end
    endtask

    task automatic test_bad_select();
        bit busy_seen = 1'b0;
        b_rdq.delete();
        pulse_load(1'b1, 5);
        repeat (6) begin
            if (b_busy) busy_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (b_err !== 1'b1 || b_rdq.size() != 0 || busy_seen) begin
            failures++;
            $display("FAIL bad_select: err=%b reads=%0d busy_seen=%b required 1/0/0", b_err, b_rdq.size(), busy_seen);
        end
    endtask

    task automatic test_rgb565();
        int d0 = b_done_cnt;
        logic [31:0] r0, r1;
        logic [11:0] v;
        b_rdq.delete(); exp_q.delete();
        pulse_load(1'b1, 4);
        checks++;
        if (b_err !== 1'b0) begin failures++; $display("FAIL rgb565_err_clear: error=%b required 0", b_err); end
        stream(1'b1, 7, -1, 1'b0, -1);
        repeat (5) @(negedge clk);
        r0 = (b_rdq.size() > 0) ? b_rdq[0] : 32'hFFFF_FFFF;
        r1 = (b_rdq.size() > 1) ? b_rdq[1] : 32'hFFFF_FFFF;
        checks++;
        if (b_rdq.size() != 2 || r0 !== 32'h0004_0000 || r1 !== 32'h0004_0001) begin
            failures++;
            $display("FAIL rgb565_reads: count=%0d addrs=%h,%h required 2 / 00040000,00040001", b_rdq.size(), r0, r1);
        end
        checks++;
        if (b_done_cnt - d0 != 1) begin failures++; $display("FAIL rgb565_done: pulses=%0d required 1", b_done_cnt - d0); end
        check_frame(1'b1, "rgb565");
        read_px(1'b1, 255, v);
        checks++;
        if (v !== 12'hF0F) begin failures++; $display("FAIL rgb565_px255: dataOut=%03h required f0f", v); end
    endtask

    task automatic test_timeout();
        int d0 = a_done_cnt;
        a_rdq.delete(); exp_q.delete();
        pulse_load(1'b0, 1);
        stream(1'b0, 11, 40, 1'b0, -1);
        checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b0 || a_done_cnt != d0) begin
            failures++;
            $display("FAIL timeout: err=%b busy=%b done_pulses=%0d required 1/0/0", a_err, a_busy, a_done_cnt - d0);
        end
        a_rdq.delete(); exp_q.delete();
        d0 = a_done_cnt;
        pulse_load(1'b0, 1);
        checks++;
        if (a_err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: error=%b required 0", a_err); end
        stream(1'b0, 50, -1, 1'b0, -1);
        check_load_end("reload", d0, 32'h0001_0000);
        check_frame(1'b0, "reload");
    endtask

    task automatic test_reset_midload();
        int d0;
        a_rdq.delete(); exp_q.delete();
        pulse_load(1'b0, 3);
        stream(1'b0, 90, 40, 1'b1, -1);
        #1;
        checks++;
        if ({a_busy, a_done, a_err, a_rd} !== 4'b0000 || a_addr !== 32'h0) begin
            failures++;
            $display("FAIL midload_reset: busy/done/err/rd=%b addr=%h required 0000 / 00000000",
                     {a_busy, a_done, a_err, a_rd}, a_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        a_rdq.delete(); exp_q.delete();
        d0 = a_done_cnt;
        pulse_load(1'b0, 0);
        stream(1'b0, 120, -1, 1'b0, -1);
        check_load_end("after_reset", d0, 32'h0000_0000);
        check_frame(1'b0, "after_reset");
    endtask

    task automatic test_load_during_recv();
        int d0 = a_done_cnt;
        a_rdq.delete(); exp_q.delete();
        pulse_load(1'b0, 2);
        a_sel = 2'd1;
        stream(1'b0, 33, -1, 1'b0, 20);
        repeat (10) @(negedge clk);
        check_load_end("ls_ignored", d0, 32'h0002_0000);
        check_frame(1'b0, "ls_ignored");
    endtask

    initial begin
        test_reset();
        test_load_img2();
        test_bad_select();
        test_rgb565();
        test_timeout();
        test_reset_midload();
        test_load_during_recv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
